// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and a small sizing helper.
package wb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    // Width of an index/counter able to hold values 0..n-1, never narrower than 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning prio, prio+1, ... modulo NUM_REQ.
module rr_priority_pick
    import wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   prio_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    assign valid_o = |req_i;

    // Scan from the lowest priority position upwards so the highest-priority hit is kept last.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((32'(prio_i) + 32'(i)) % NUM_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter with per-cyc grant hold and an unanswered-strobe watchdog.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [NUM_MASTERS-1:0]          m_rty_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic [WB_DAT_W-1:0]             s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
    localparam int unsigned WDT_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);
    localparam logic             WDT_EN   = (TIMEOUT_CYCLES != 0);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] prio_q, prio_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             busy;
    logic             slv_resp;
    logic             wdt_fire;
    logic [IDX_W-1:0] prio_after_gnt;

    rr_priority_pick #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (m_cyc_i),
        .prio_i  (prio_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign busy           = (state_q == ARB_BUSY);
    assign slv_resp       = s_ack_i | s_err_i | s_rty_i;
    // A real slave response in the firing cycle takes precedence over the watchdog.
    assign wdt_fire       = WDT_EN & s_stb_o & ~slv_resp & (wdt_q == WDT_LAST);
    assign prio_after_gnt = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;

    // Forward the granted master's request to the slave; everything stays 0 while idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        grant_o = '0;
        if (busy) begin
            s_cyc_o        = m_cyc_i[gnt_q];
            // stb is masked by cyc so dropping cyc releases the slave in the same cycle.
            s_stb_o        = m_cyc_i[gnt_q] & m_stb_i[gnt_q];
            s_we_o         = m_we_i[gnt_q];
            s_adr_o        = m_adr_i[WB_ADR_W*gnt_q +: WB_ADR_W];
            s_sel_o        = m_sel_i[WB_SEL_W*gnt_q +: WB_SEL_W];
            s_dat_o        = m_dat_i[WB_DAT_W*gnt_q +: WB_DAT_W];
            grant_o[gnt_q] = 1'b1;
        end
    end

    // Route slave responses to the granted master only; responses without a live stb are dropped.
    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (busy) begin
            m_dat_o[WB_DAT_W*gnt_q +: WB_DAT_W] = s_dat_i;
            m_ack_o[gnt_q] = s_stb_o & s_ack_i;
            m_err_o[gnt_q] = s_stb_o & (s_err_i | wdt_fire);
            m_rty_o[gnt_q] = s_stb_o & s_rty_i;
        end
    end

    // Next-state: arbitrate when idle, hold grant until cyc drops, run the watchdog while busy.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        wdt_d   = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_BUSY;
                    gnt_d   = pick_idx;
                end
            end
            ARB_BUSY: begin
                if (!m_cyc_i[gnt_q]) begin
                    state_d = ARB_IDLE;
                    prio_d  = prio_after_gnt;
                end else if (WDT_EN && s_stb_o && !slv_resp && !wdt_fire) begin
                    wdt_d = wdt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            prio_q  <= '0;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            wdt_q   <= wdt_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration and watchdog rules.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [32*N-1:0] m_adr = '0, m_wdat = '0;
    logic [4*N-1:0]  m_sel = '0;
    logic [31:0]     s_dat = '0;
    logic            s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [32*N-1:0] m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [3:0]      s_sel_o;

    int total = 0;
    int bad   = 0;

    // Model state: whether the bus is owned, by whom, rotation start, unanswered-strobe count.
    bit md_busy = 0;
    int md_owner = 0;
    int md_prio = 0;
    int md_wait = 0;

    logic [N-1:0]    e_grant, e_ack, e_err, e_rty;
    logic            e_cyc, e_stb, e_we, e_resp, e_fire;
    logic [31:0]     e_adr, e_dat;
    logic [3:0]      e_sel;
    logic [32*N-1:0] e_mdat;

    wb_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_wdat),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .s_rty_i (s_rty),
        .grant_o (grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the current cycle from the model and the present inputs.
    task automatic model_exp();
        e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_mdat = '0;
        e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_resp = s_ack | s_err | s_rty;
        e_fire = 0;
        if (md_busy) begin
            e_grant[md_owner] = 1'b1;
            e_cyc  = m_cyc[md_owner];
            e_stb  = m_cyc[md_owner] && m_stb[md_owner];
            e_we   = m_we[md_owner];
            e_adr  = m_adr[32*md_owner +: 32];
            e_dat  = m_wdat[32*md_owner +: 32];
            e_sel  = m_sel[4*md_owner +: 4];
            e_mdat[32*md_owner +: 32] = s_dat;
            e_fire = (TO > 0) && e_stb && !e_resp && (md_wait == TO - 1);
            e_ack[md_owner] = e_stb && s_ack;
            e_err[md_owner] = e_stb && (s_err || e_fire);
            e_rty[md_owner] = e_stb && s_rty;
        end
    endtask

    // Advance the model across a clock edge using the inputs present at that edge.
    task automatic model_update();
        model_exp();
        if (rst) begin
            md_busy = 0; md_prio = 0; md_wait = 0;
        end else if (!md_busy) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (md_prio + i) % N;
                if (m_cyc[c] && !md_busy) begin
                    md_busy  = 1;
                    md_owner = c;
                end
            end
            md_wait = 0;
        end else if (!m_cyc[md_owner]) begin
            md_busy = 0;
            md_prio = (md_owner + 1) % N;
            md_wait = 0;
        end else begin
            md_wait = (e_stb && !e_resp && !e_fire) ? md_wait + 1 : 0;
        end
    endtask

    // Sample on the falling edge and compare every output against the model.
    task automatic settle();
        @(negedge clk);
        model_exp();
        chk("grant", grant_o, e_grant);
        chk("s_cyc", s_cyc_o, e_cyc);
        chk("s_stb", s_stb_o, e_stb);
        chk("s_we", s_we_o, e_we);
        chk("s_adr", s_adr_o, e_adr);
        chk("s_sel", s_sel_o, e_sel);
        chk("s_dat", s_dat_o, e_dat);
        chk("m_ack", m_ack_o, e_ack);
        chk("m_err", m_err_o, e_err);
        chk("m_rty", m_rty_o, e_rty);
        chk("m_dat", m_dat_o, e_mdat);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[32*k +: 32]  = adr;
        m_wdat[32*k +: 32] = dat;
        m_sel[4*k +: 4]    = 4'hF;
    endtask

    task automatic clear_all();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1;
        tick();
        rst = 0;
    endtask

    int  seq[$];
    int  busy_cnt;
    bit  silent;

    initial begin
        // Reset state
        rst = 1;
        tick();
        tick();
        rst = 0;
        settle();
        chk("rst_grant", grant_o, 0);
        chk("rst_scyc", s_cyc_o, 0);
        tick();

        // Single master write then read
        set_m(0, 1, 1, 1, 32'h0, 32'hDEADBEEF);
        s_ack = 1;
        settle();
        chk("t1_idle_scyc", s_cyc_o, 0);
        chk("t1_idle_ack", m_ack_o, 0);
        tick();
        settle();
        chk("t1_scyc", s_cyc_o, 1);
        chk("t1_wdat", s_dat_o, 32'hDEADBEEF);
        chk("t1_wack", m_ack_o, 2'b01);
        tick();
        set_m(0, 1, 1, 0, 32'h0, 32'h0);
        s_dat = 32'hDEADBEEF;
        settle();
        chk("t1_rdat", m_dat_o[31:0], 32'hDEADBEEF);
        chk("t1_m1dat", m_dat_o[63:32], 0);
        chk("t1_rack", m_ack_o, 2'b01);
        tick();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        s_ack = 0;
        settle();
        chk("t1_rel_scyc", s_cyc_o, 0);
        tick();
        settle();
        chk("t1_idle_after", grant_o, 0);
        tick();

        // Simultaneous requests after reset
        do_reset();
        set_m(0, 1, 0, 0, 32'h10, 0);
        set_m(1, 1, 0, 0, 32'h20, 0);
        settle(); tick();
        settle();
        chk("sim_first", grant_o, 2'b01);
        tick();
        m_cyc[0] = 0;
        settle();
        chk("sim_drop_scyc", s_cyc_o, 0);
        tick();
        settle();
        chk("sim_gap", grant_o, 2'b00);
        tick();
        settle();
        chk("sim_second", grant_o, 2'b10);
        tick();
        m_cyc[1] = 0;
        settle(); tick();
        settle(); tick();
        m_cyc = 2'b11;
        settle(); tick();
        settle();
        chk("sim_prio0", grant_o, 2'b01);
        tick();
        clear_all();
        settle(); tick();

        // Fairness with continuous requests
        do_reset();
        busy_cnt = 0;
        for (int c = 0; c < 60 && seq.size() < 6; c++) begin
            if (grant_o == '0) begin
                busy_cnt = 0;
                m_cyc = '1;
            end else begin
                busy_cnt++;
                if (busy_cnt == 1) seq.push_back(grant_o[1] ? 1 : 0);
                if (busy_cnt == 2) m_cyc = m_cyc & ~grant_o;
            end
            settle();
            tick();
        end
        chk("fair_count", seq.size(), 6);
        for (int i = 0; i < seq.size() && i < 6; i++) chk("fair_seq", seq[i], i % 2);
        clear_all();
        settle(); tick();
        settle(); tick();

        // No preemption
        do_reset();
        set_m(1, 1, 1, 1, 32'h100, 32'h11);
        settle(); tick();
        set_m(0, 1, 1, 1, 32'hAAAA0000, 32'h22);
        for (int i = 0; i < 3; i++) begin
            m_adr[63:32] = 32'h100 + 32'(4 * i);
            s_ack = 1;
            settle();
            chk("np_adr", s_adr_o, 32'h100 + 32'(4 * i));
            chk("np_ack", m_ack_o, 2'b10);
            tick();
        end
        m_cyc[1] = 0;
        settle();
        chk("np_late_ack", m_ack_o, 0);
        tick();
        settle();
        chk("np_gap", grant_o, 0);
        tick();
        settle();
        chk("np_m0_grant", grant_o, 2'b01);
        chk("np_m0_adr", s_adr_o, 32'hAAAA0000);
        chk("np_m0_ack", m_ack_o, 2'b01);
        tick();
        clear_all();
        settle(); tick();
        settle(); tick();

        // Watchdog fires on the 16th unanswered strobe cycle
        do_reset();
        set_m(0, 1, 1, 0, 32'hF000_0000, 0);
        settle(); tick();
        for (int k = 1; k <= 20; k++) begin
            settle();
            chk("wdt_err", m_err_o[0], (k == TO) ? 1 : 0);
            tick();
        end
        m_cyc[0] = 0;
        settle(); tick();
        settle(); tick();
        // Slave answers in the firing cycle: ack wins, no err
        m_cyc[0] = 1;
        settle(); tick();
        for (int k = 1; k <= TO; k++) begin
            s_ack = (k == TO);
            settle();
            chk("wdt_race_err", m_err_o, 0);
            chk("wdt_race_ack", m_ack_o, (k == TO) ? 2'b01 : 2'b00);
            tick();
        end
        clear_all();
        settle(); tick();
        settle(); tick();

        // Reset mid-transfer
        do_reset();
        set_m(0, 1, 0, 0, 0, 0);
        settle(); tick();
        settle(); tick();
        m_cyc[0] = 0;
        settle(); tick();
        set_m(1, 1, 1, 1, 32'h300, 32'h33);
        settle(); tick();
        settle();
        chk("rs_pre_grant", grant_o, 2'b10);
        tick();
        m_cyc[0] = 1;
        s_ack = 1;
        rst = 1;
        settle(); tick();
        rst = 0;
        settle();
        chk("rs_grant", grant_o, 0);
        chk("rs_scyc", s_cyc_o, 0);
        chk("rs_ack", m_ack_o, 0);
        chk("rs_err", m_err_o, 0);
        tick();
        settle();
        chk("rs_next", grant_o, 2'b01);
        tick();
        clear_all();
        settle(); tick();
        settle(); tick();

        // Randomized traffic against the model
        silent = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 23) == 0) m_cyc[k] = ~m_cyc[k];
                m_stb[k] = ($urandom_range(0, 3) != 0);
                m_we[k]  = 1'($urandom_range(0, 1));
                m_adr[32*k +: 32]  = $urandom;
                m_wdat[32*k +: 32] = $urandom;
                m_sel[4*k +: 4]    = 4'($urandom);
            end
            if ($urandom_range(0, 49) == 0) silent = ~silent;
            s_ack = !silent && ($urandom_range(0, 2) == 0);
            s_err = !silent && ($urandom_range(0, 15) == 0);
            s_rty = !silent && ($urandom_range(0, 15) == 0);
            s_dat = $urandom;
            rst   = ($urandom_range(0, 199) == 0);
            settle();
            tick();
        end
        rst = 0;
        clear_all();
        settle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
